fp16_to_int: RTL
================

FP16_TO_INT -- requirements
Module: fp16_to_int

Interface
REQ-001 SHALL have parameter MAX_RSHIFT, default 12: right-shift clamp; any right shift of 12 or more yields magnitude 0.
REQ-002 SHALL have port clk_44  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset_44  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port data_incoming_44  in  1  start strobe, sampled on clk_44 rising edge.
REQ-005 SHALL have port cvtIn_44  in  16  IEEE-754 binary16 operand (sign, 5-bit exp bias 15, 10-bit frac).
REQ-006 SHALL have port cvtOut_44  out  16  two's-complement signed integer result, registered.
REQ-007 SHALL have port done_44  out  1  one-cycle pulse, cvtOut_44 and flags valid from this cycle.
REQ-008 SHALL have port busy_44  out  1  high from capture until the cycle done_44 asserts.
REQ-009 SHALL have ports overflow_44 and invalid_44  out  1 each  status, registered with cvtOut_44.

Function
REQ-010 SHALL implement FSM IDLE -> LOAD -> SHIFT -> FIN -> IDLE.
REQ-011 SHALL capture cvtIn_44 only in IDLE when data_incoming_44=1; strobes in any other state SHALL be ignored.
REQ-012 LOAD SHALL classify: e=0 -> zero; e=31, frac=0 -> infinity; e=31, frac!=0 -> NaN; else normal with mantissa m={1,frac} (11 bits).
REQ-013 Normal, e<25: SHALL right-shift m one bit per cycle for k=min(25-e, MAX_RSHIFT) cycles, tracking guard (last bit out) and sticky (OR of earlier bits out).
REQ-014 Normal, e>=25: SHALL left-shift m one bit per cycle for k=e-25 cycles into a 17-bit magnitude.
REQ-015 Zero, infinity, NaN SHALL use k=0 (SHIFT state skipped).
REQ-016 FIN SHALL apply sign (negate if sign=1), saturate, set flags, then return to IDLE.
REQ-017 Latency: done_44 SHALL assert exactly k+2 cycles after the capture edge; busy_44 SHALL drop the same cycle; new strobe accepted that cycle.
REQ-018 Saturation: magnitude > 32767 positive -> 0x7FFF, overflow_44=1; magnitude > 32768 negative -> 0x8000, overflow_44=1; exactly -32768 -> 0x8000, overflow_44=0.
REQ-019 Infinity SHALL give 0x7FFF/0x8000 by sign with overflow_44=1; NaN SHALL give 0x0000 with invalid_44=1.
REQ-020 Zero and subnormal inputs (either sign) SHALL give 0x0000, no flags.
REQ-021 cvtOut_44 and flags SHALL hold their value until the next FIN.
REQ-022 Default rounding SHALL be truncation toward zero (guard/sticky discarded).

Reset
REQ-023 reset_44=0 SHALL immediately, independent of clk_44, force IDLE, cvtOut_44=0x0000, done_44=0, busy_44=0, overflow_44=0, invalid_44=0.
REQ-024 Reset mid-conversion SHALL abort without a done_44 pulse; the first strobe after release SHALL start a fresh conversion.

Configuration
REQ-025 With FP2INT_ROUND_EN defined, FIN SHALL round magnitude to nearest, ties to even (increment when guard=1 and (sticky=1 or LSB=1)) before sign and saturation; latency unchanged.
REQ-026 Without FP2INT_ROUND_EN, REQ-022 truncation SHALL apply and guard/sticky logic SHALL be absent.

Verification
REQ-027 cvtIn_44=0x4E46 (25.09) strobe -> done_44 8 cycles later, cvtOut_44=0x0019, no flags (both modes).
REQ-028 cvtIn_44=0xCB80 (-15.0) -> done_44 after 9 cycles, cvtOut_44=0xFFF1.
REQ-029 cvtIn_44=0x3E00 (1.5) -> truncate 0x0001; with FP2INT_ROUND_EN 0x0002; cvtIn_44=0xB800 (-0.5) -> 0x0000 in both modes.
REQ-030 cvtIn_44=0x7BFF (65504) -> 0x7FFF, overflow_44=1 after 7 cycles; 0xF800 (-32768) -> 0x8000, overflow_44=0; 0xFC00 -> 0x8000, overflow_44=1; 0x7E00 -> 0x0000, invalid_44=1 after 2 cycles.
REQ-031 Strobe 0x4E46, second strobe 0x4200 three cycles later, reset_44 pulsed low during SHIFT of a third op -> second strobe ignored, no done_44 for aborted op, all outputs 0 immediately on reset assertion.

Source files
------------

// File: rtl/fp16_to_int.sv
// Serial binary16 -> int16 converter: one mantissa shift per clock, saturating.
// Define FP2INT_ROUND_EN for round-to-nearest-even; default build truncates.
module fp16_to_int #(
  parameter int MAX_RSHIFT = 12
) (
  input  logic        clk_44,
  input  logic        reset_44,
  input  logic        data_incoming_44,
  input  logic [15:0] cvtIn_44,
  output logic [15:0] cvtOut_44,
  output logic        done_44,
  output logic        busy_44,
  output logic        overflow_44,
  output logic        invalid_44
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_FIN
  } state_t;

  typedef enum logic [1:0] {
    C_ZERO,
    C_INF,
    C_NAN,
    C_NORM
  } cls_t;

  localparam logic [5:0] LP_RMAX = 6'(MAX_RSHIFT);

  state_t      r_state;
  cls_t        r_cls;
  logic [15:0] r_in;
  logic        r_left;
  logic [5:0]  r_cnt;
  logic [16:0] r_mag;
`ifdef FP2INT_ROUND_EN
  logic        r_guard;
  logic        r_sticky;
`endif

  logic [4:0]  w_exp;
  logic [9:0]  w_frac;
  logic        w_sign;
  logic [5:0]  w_rdist;
  logic [5:0]  w_rk;
  logic [5:0]  w_lk;
  logic [16:0] w_mag;
  logic [15:0] w_res;
  logic        w_ovf;
  logic        w_inv;

  assign w_sign  = r_in[15];
  assign w_exp   = r_in[14:10];
  assign w_frac  = r_in[9:0];
  assign w_rdist = 6'd25 - {1'b0, w_exp};
  assign w_rk    = (w_rdist >= LP_RMAX) ? LP_RMAX : w_rdist;
  assign w_lk    = {1'b0, w_exp} - 6'd25;

`ifdef FP2INT_ROUND_EN
  logic w_inc;
  assign w_inc = r_guard & (r_sticky | r_mag[0]);
  assign w_mag = r_mag + {16'd0, w_inc};
`else
  assign w_mag = r_mag;
`endif

  // Negative range is one wider: -32768 is exact, not an overflow.
  always_comb begin
    w_res = 16'h0000;
    w_ovf = 1'b0;
    w_inv = 1'b0;
    unique case (r_cls)
      C_ZERO: w_res = 16'h0000;
      C_NAN:  w_inv = 1'b1;
      C_INF: begin
        w_res = w_sign ? 16'h8000 : 16'h7FFF;
        w_ovf = 1'b1;
      end
      C_NORM: begin
        if (!w_sign) begin
          if (w_mag > 17'd32767) begin
            w_res = 16'h7FFF;
            w_ovf = 1'b1;
          end else begin
            w_res = w_mag[15:0];
          end
        end else begin
          if (w_mag > 17'd32768) begin
            w_res = 16'h8000;
            w_ovf = 1'b1;
          end else begin
            w_res = ~w_mag[15:0] + 16'd1;
          end
        end
      end
      default: w_res = 16'h0000;
    endcase
  end

  always_ff @(posedge clk_44 or negedge reset_44) begin
    if (!reset_44) begin
      r_state     <= S_IDLE;
      r_cls       <= C_ZERO;
      r_in        <= 16'h0000;
      r_left      <= 1'b0;
      r_cnt       <= 6'd0;
      r_mag       <= 17'd0;
`ifdef FP2INT_ROUND_EN
      r_guard     <= 1'b0;
      r_sticky    <= 1'b0;
`endif
      cvtOut_44   <= 16'h0000;
      done_44     <= 1'b0;
      busy_44     <= 1'b0;
      overflow_44 <= 1'b0;
      invalid_44  <= 1'b0;
    end else begin
      done_44 <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (data_incoming_44) begin
            r_in    <= cvtIn_44;
            busy_44 <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_mag <= {6'd0, 1'b1, w_frac};
`ifdef FP2INT_ROUND_EN
          r_guard  <= 1'b0;
          r_sticky <= 1'b0;
`endif
          if (w_exp == 5'd0) begin
            r_cls   <= C_ZERO;
            r_state <= S_FIN;
          end else if (w_exp == 5'd31) begin
            r_cls   <= (w_frac == 10'd0) ? C_INF : C_NAN;
            r_state <= S_FIN;
          end else if (w_exp < 5'd25) begin
            r_cls   <= C_NORM;
            r_left  <= 1'b0;
            r_cnt   <= w_rk;
            r_state <= S_SHIFT;
          end else begin
            r_cls   <= C_NORM;
            r_left  <= 1'b1;
            r_cnt   <= w_lk;
            r_state <= (w_lk == 6'd0) ? S_FIN : S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_left) begin
            r_mag <= r_mag << 1;
          end else begin
            r_mag <= r_mag >> 1;
`ifdef FP2INT_ROUND_EN
            r_guard  <= r_mag[0];
            r_sticky <= r_sticky | r_guard;
`endif
          end
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) r_state <= S_FIN;
        end
        S_FIN: begin
          cvtOut_44   <= w_res;
          overflow_44 <= w_ovf;
          invalid_44  <= w_inv;
          done_44     <= 1'b1;
          busy_44     <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
